// File: rtl/udp_fragment_generator_if.sv
// Bus bundle for udp_fragment_generator: datagram byte input, fragment
// header handshake and the pull-driven fragment byte stream.
// slave  = the fragment generator, master = datagram source plus IP framer.
interface udp_fragment_generator_if;
  logic [7:0]  data;
  logic        data_enable;
  logic        data_last;
  logic [15:0] packet_id;
  logic        ready;
  logic        overflow;

  logic        fragment_ready;
  logic        fragment_accept;
  logic [12:0] fragment_offset;
  logic        more_fragments;
  logic [15:0] fragment_length;
  logic [15:0] current_packet_id;

  logic        push_data_enable;
  logic [8:0]  push_data;
  logic        push_data_valid;
  logic        push_data_last;

  modport slave (
    input  data, data_enable, data_last, packet_id, fragment_accept, push_data_enable,
    output ready, overflow, fragment_ready, fragment_offset, more_fragments,
           fragment_length, current_packet_id, push_data, push_data_valid, push_data_last
  );

  modport master (
    output data, data_enable, data_last, packet_id, fragment_accept, push_data_enable,
    input  ready, overflow, fragment_ready, fragment_offset, more_fragments,
           fragment_length, current_packet_id, push_data, push_data_valid, push_data_last
  );
endinterface

// File: rtl/udp_fragment_generator.sv
// udp_fragment_generator: buffers one outbound UDP datagram in an internal
// FIFO, then emits it as IPv4 fragments of at most MAX_FRAGMENT_PAYLOAD bytes.
// Each fragment is announced with header fields and streamed under a pull
// handshake. FIFO_DEPTH must be a power of two (pointers wrap naturally).
// Optional feature macro: UDP_FRAGMENT_STATS_EN adds datagram_count and
// fragment_count outputs.
module udp_fragment_generator #(
  parameter int MAX_FRAGMENT_PAYLOAD = 1480,
  parameter int FIFO_DEPTH           = 4096
) (
  input  logic                    clock,
  input  logic                    reset_n,
  udp_fragment_generator_if.slave bus
`ifdef UDP_FRAGMENT_STATS_EN
  ,
  output logic [31:0]             datagram_count,
  output logic [31:0]             fragment_count
`endif
);

  localparam int            AW      = $clog2(FIFO_DEPTH);
  localparam logic [15:0]   MAX_LEN = 16'(MAX_FRAGMENT_PAYLOAD);
  localparam logic [AW:0]   DEPTH   = (AW + 1)'(FIFO_DEPTH);
  localparam logic [AW-1:0] PTR_ONE = AW'(1);

  typedef enum logic [1:0] {
    S_IDLE,
    S_CAPTURE,
    S_HEADER,
    S_STREAM
  } state_t;

  state_t        state_q, state_d;

  logic [7:0]    in_data_q, in_data_d;
  logic          in_enable_q, in_enable_d;
  logic          in_last_q, in_last_d;
  logic [15:0]   in_id_q, in_id_d;

  logic [15:0]   total_len_q, total_len_d;
  logic [12:0]   sent_units_q, sent_units_d;
  logic [15:0]   packet_id_q, packet_id_d;
  logic [15:0]   wr_pos_q, wr_pos_d;
  logic [15:0]   frag_len_q, frag_len_d;
  logic          frag_more_q, frag_more_d;
  logic [15:0]   issued_q, issued_d;

  logic [AW-1:0] wr_ptr_q, wr_ptr_d;
  logic [AW-1:0] rd_ptr_q, rd_ptr_d;
  logic [AW:0]   count_q, count_d;

  logic          valid_q, valid_d;
  logic          last_q, last_d;
  logic          overflow_q, overflow_d;
  logic          ready_q, ready_d;

  logic [8:0]    mem [FIFO_DEPTH];
  logic [8:0]    rd_data_q;

  logic [15:0]   remaining;
  logic [15:0]   hdr_len;
  logic          hdr_more;
  logic          fifo_full;
  logic          fifo_empty;
  logic          accepting;
  logic          wr_en;
  logic          wr_first;
  logic          rd_en;
  logic          final_read;

  // Input bytes are registered once before they reach the FIFO write port.
  always_comb begin
    in_data_d   = bus.data;
    in_enable_d = bus.data_enable;
    in_last_d   = bus.data_last;
    in_id_d     = bus.packet_id;
  end

  // Header arithmetic and FIFO read/write qualification. Every fragment but
  // the last is exactly MAX_FRAGMENT_PAYLOAD long, so a byte starts a
  // fragment whenever its datagram position is a multiple of that size; the
  // flag is stored as bit 8 of the FIFO entry and comes back out as push_data[8].
  always_comb begin
    remaining  = total_len_q - {sent_units_q, 3'b000};
    hdr_more   = remaining > MAX_LEN;
    hdr_len    = hdr_more ? MAX_LEN : remaining;
    fifo_full  = (count_q == DEPTH);
    fifo_empty = (count_q == '0);
    accepting  = (state_q == S_IDLE) || (state_q == S_CAPTURE);
    wr_en      = in_enable_q && accepting && !fifo_full;
    wr_first   = (state_q == S_IDLE) || (wr_pos_q == 16'd0);
    rd_en      = (state_q == S_STREAM) && bus.push_data_enable &&
                 (issued_q < frag_len_q) && !fifo_empty;
    final_read = rd_en && (issued_q == frag_len_q - 16'd1);
  end

  // FIFO pointers, occupancy and the one-cycle output pipeline flags.
  always_comb begin
    wr_ptr_d   = wr_en ? wr_ptr_q + PTR_ONE : wr_ptr_q;
    rd_ptr_d   = rd_en ? rd_ptr_q + PTR_ONE : rd_ptr_q;
    count_d    = count_q + {{AW{1'b0}}, wr_en} - {{AW{1'b0}}, rd_en};
    valid_d    = rd_en;
    last_d     = final_read;
    overflow_d = in_enable_q && accepting && fifo_full;
  end

  // Next-state and datagram bookkeeping for capture, header and stream phases.
  always_comb begin
    state_d      = state_q;
    total_len_d  = total_len_q;
    sent_units_d = sent_units_q;
    packet_id_d  = packet_id_q;
    wr_pos_d     = wr_pos_q;
    frag_len_d   = frag_len_q;
    frag_more_d  = frag_more_q;
    issued_d     = issued_q;

    unique case (state_q)
      S_IDLE: begin
        if (in_enable_q) begin
          packet_id_d  = in_id_q;
          total_len_d  = 16'd1;
          sent_units_d = 13'd0;
          wr_pos_d     = 16'd1;
          state_d      = in_last_q ? S_HEADER : S_CAPTURE;
        end
      end
      S_CAPTURE: begin
        if (in_enable_q) begin
          if (!fifo_full) begin
            total_len_d = total_len_q + 16'd1;
            wr_pos_d    = (wr_pos_q == MAX_LEN - 16'd1) ? 16'd0 : wr_pos_q + 16'd1;
          end
          if (in_last_q) begin
            state_d = S_HEADER;
          end
        end
      end
      S_HEADER: begin
        if (bus.fragment_accept) begin
          frag_len_d  = hdr_len;
          frag_more_d = hdr_more;
          issued_d    = 16'd0;
          state_d     = S_STREAM;
        end
      end
      S_STREAM: begin
        if (rd_en) begin
          issued_d = issued_q + 16'd1;
        end
        if (final_read) begin
          sent_units_d = sent_units_q + frag_len_q[15:3];
        end
        if (valid_q && last_q) begin
          state_d = frag_more_q ? S_HEADER : S_IDLE;
        end
      end
      default: state_d = S_IDLE;
    endcase

    ready_d = (state_d == S_IDLE);
  end

  // State and control registers; reset drops everything, including FIFO contents.
  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      state_q      <= S_IDLE;
      in_data_q    <= 8'd0;
      in_enable_q  <= 1'b0;
      in_last_q    <= 1'b0;
      in_id_q      <= 16'd0;
      total_len_q  <= 16'd0;
      sent_units_q <= 13'd0;
      packet_id_q  <= 16'd0;
      wr_pos_q     <= 16'd0;
      frag_len_q   <= 16'd0;
      frag_more_q  <= 1'b0;
      issued_q     <= 16'd0;
      wr_ptr_q     <= '0;
      rd_ptr_q     <= '0;
      count_q      <= '0;
      valid_q      <= 1'b0;
      last_q       <= 1'b0;
      overflow_q   <= 1'b0;
      ready_q      <= 1'b0;
    end else begin
      state_q      <= state_d;
      in_data_q    <= in_data_d;
      in_enable_q  <= in_enable_d;
      in_last_q    <= in_last_d;
      in_id_q      <= in_id_d;
      total_len_q  <= total_len_d;
      sent_units_q <= sent_units_d;
      packet_id_q  <= packet_id_d;
      wr_pos_q     <= wr_pos_d;
      frag_len_q   <= frag_len_d;
      frag_more_q  <= frag_more_d;
      issued_q     <= issued_d;
      wr_ptr_q     <= wr_ptr_d;
      rd_ptr_q     <= rd_ptr_d;
      count_q      <= count_d;
      valid_q      <= valid_d;
      last_q       <= last_d;
      overflow_q   <= overflow_d;
      ready_q      <= ready_d;
    end
  end

  // FIFO storage with one-cycle read latency; left unreset so it maps to RAM.
  always_ff @(posedge clock) begin
    if (wr_en) begin
      mem[wr_ptr_q] <= {wr_first, in_data_q};
    end
    if (rd_en) begin
      rd_data_q <= mem[rd_ptr_q];
    end
  end

`ifdef UDP_FRAGMENT_STATS_EN
  logic [31:0] datagram_count_q, datagram_count_d;
  logic [31:0] fragment_count_q, fragment_count_d;

  // Free-running statistics: datagrams closed by capture and fragments accepted.
  always_comb begin
    datagram_count_d = datagram_count_q;
    fragment_count_d = fragment_count_q;
    if (accepting && (state_d == S_HEADER)) begin
      datagram_count_d = datagram_count_q + 32'd1;
    end
    if ((state_q == S_HEADER) && bus.fragment_accept) begin
      fragment_count_d = fragment_count_q + 32'd1;
    end
  end

  // Statistics registers.
  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      datagram_count_q <= 32'd0;
      fragment_count_q <= 32'd0;
    end else begin
      datagram_count_q <= datagram_count_d;
      fragment_count_q <= fragment_count_d;
    end
  end

  assign datagram_count = datagram_count_q;
  assign fragment_count = fragment_count_q;
`endif

  assign bus.ready             = ready_q;
  assign bus.overflow          = overflow_q;
  assign bus.fragment_ready    = (state_q == S_HEADER);
  assign bus.fragment_offset   = sent_units_q;
  assign bus.more_fragments    = hdr_more;
  assign bus.fragment_length   = hdr_len;
  assign bus.current_packet_id = packet_id_q;
  assign bus.push_data         = valid_q ? rd_data_q : 9'd0;
  assign bus.push_data_valid   = valid_q;
  assign bus.push_data_last    = last_q;

endmodule

// File: tb/tb_udp_fragment_generator.sv
// Self-checking bench for udp_fragment_generator. A datagram-level model
// turns each sent datagram into the expected header list and byte stream;
// one compare process checks headers and bytes as the DUT presents them.
module tb_udp_fragment_generator;
  localparam int MAX   = 1480;
  localparam int DEPTH = 4096;

  typedef struct packed {
    logic [15:0] len;
    logic [12:0] off;
    logic        mf;
    logic [15:0] id;
  } hdr_t;

  logic clock = 1'b0;
  logic reset_n;

  udp_fragment_generator_if bus();

`ifdef UDP_FRAGMENT_STATS_EN
  logic [31:0] datagram_count;
  logic [31:0] fragment_count;
`endif

  udp_fragment_generator #(
    .MAX_FRAGMENT_PAYLOAD(MAX),
    .FIFO_DEPTH(DEPTH)
  ) dut (
    .clock(clock),
    .reset_n(reset_n),
    .bus(bus)
`ifdef UDP_FRAGMENT_STATS_EN
    ,
    .datagram_count(datagram_count),
    .fragment_count(fragment_count)
`endif
  );

  always #5 clock = ~clock;

  int compare_count = 0;
  int fail_count    = 0;

  logic [9:0] exp_byte[$];
  hdr_t       exp_hdr[$];

  bit stall_mode = 1'b0;
  int bytes_seen, first_seen, last_seen, overflow_seen, n_seen, len_sum;
  int seen_len[8];
  int seen_off[8];
  int seen_mf[8];
  int seen_id[8];

  logic [9:0] cur_byte;
  hdr_t       cur_hdr;

  // Single comparison point: every failure prints one FAIL line.
  task automatic checkOutput(input string name, input logic [31:0] actual, input logic [31:0] expected);
    compare_count++;
    if (actual !== expected) begin
      fail_count++;
      $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h", name, actual, expected);
    end
  endtask

  function automatic logic [7:0] byteOf(input int k, input int seed);
    int v;
    v = k * 13 + seed + (k >> 8);
    return v[7:0];
  endfunction

  task automatic clearSeen();
    bytes_seen = 0; first_seen = 0; last_seen = 0; overflow_seen = 0;
    n_seen = 0; len_sum = 0;
    for (int i = 0; i < 8; i++) begin
      seen_len[i] = -1; seen_off[i] = -1; seen_mf[i] = -1; seen_id[i] = -1;
    end
  endtask

  // Build the expectation from datagram rules, then drive the bytes in.
  task automatic applyStimulus(input int len, input logic [15:0] id, input int seed);
    int   kept;
    int   c;
    hdr_t h;
    c = 0;
    while (!bus.ready && c < 2000) begin
      @(negedge clock);
      c++;
    end
    checkOutput("ready_before_send", 32'(bus.ready), 32'd1);

    kept = (len > DEPTH) ? DEPTH : len;
    for (int k = 0; k < kept; k++) begin
      exp_byte.push_back({((k % MAX) == MAX - 1) || (k == kept - 1),
                          (k % MAX) == 0, byteOf(k, seed)});
    end
    for (int off = 0; off < kept; off += MAX) begin
      h.len = 16'(((kept - off) > MAX) ? MAX : (kept - off));
      h.off = 13'(off / 8);
      h.mf  = (kept - off) > MAX;
      h.id  = id;
      exp_hdr.push_back(h);
    end

    for (int i = 0; i < len; i++) begin
      bus.data        = byteOf(i, seed);
      bus.data_enable = 1'b1;
      bus.data_last   = (i == len - 1);
      bus.packet_id   = (i == 0) ? id : ~id;
      @(negedge clock);
    end
    bus.data_enable = 1'b0;
    bus.data_last   = 1'b0;
    bus.packet_id   = 16'h0000;
    bus.data        = 8'h00;
  endtask

  task automatic waitDone(input string name, input int limit);
    int c;
    c = 0;
    while (!((exp_byte.size() == 0) && (exp_hdr.size() == 0) && bus.ready) && c < limit) begin
      @(negedge clock);
      c++;
    end
    checkOutput({name, "_ready"}, 32'(bus.ready), 32'd1);
    checkOutput({name, "_pending"}, 32'(exp_byte.size() + exp_hdr.size()), 32'd0);
  endtask

  // Framer side: accept headers, pull bytes, compare both against the model.
  initial begin
    bus.fragment_accept  = 1'b0;
    bus.push_data_enable = 1'b0;
    forever begin
      @(negedge clock);
      if (!reset_n) begin
        bus.fragment_accept  = 1'b0;
        bus.push_data_enable = 1'b0;
      end else begin
        if (bus.overflow) overflow_seen++;
        if (bus.push_data_valid) begin
          if (exp_byte.size() == 0) begin
            checkOutput("stray_byte_valid", 32'(bus.push_data_valid), 32'd0);
          end else begin
            cur_byte = exp_byte.pop_front();
            checkOutput("push_data", 32'({bus.push_data_last, bus.push_data}), 32'(cur_byte));
            bytes_seen++;
            if (bus.push_data[8]) first_seen++;
            if (bus.push_data_last) last_seen++;
          end
        end
        if (bus.fragment_ready && !bus.fragment_accept) begin
          if (exp_hdr.size() == 0) begin
            checkOutput("stray_header", 32'(bus.fragment_ready), 32'd0);
          end else begin
            cur_hdr = exp_hdr.pop_front();
            checkOutput("frag_length", 32'(bus.fragment_length), 32'(cur_hdr.len));
            checkOutput("frag_offset", 32'(bus.fragment_offset), 32'(cur_hdr.off));
            checkOutput("more_fragments", 32'(bus.more_fragments), 32'(cur_hdr.mf));
            checkOutput("packet_id", 32'(bus.current_packet_id), 32'(cur_hdr.id));
          end
          if (n_seen < 8) begin
            seen_len[n_seen] = int'(bus.fragment_length);
            seen_off[n_seen] = int'(bus.fragment_offset);
            seen_mf[n_seen]  = int'(bus.more_fragments);
            seen_id[n_seen]  = int'(bus.current_packet_id);
          end
          n_seen++;
          len_sum += int'(bus.fragment_length);
          bus.fragment_accept = 1'b1;
        end else begin
          bus.fragment_accept = 1'b0;
        end
        bus.push_data_enable = stall_mode ? 1'($urandom_range(0, 1)) : 1'b1;
      end
    end
  end

  initial begin
    #800us;
    $display("[TB] FAIL watchdog: simulation did not finish");
    $fatal(1, "[TB] watchdog expired");
  end

  initial begin
    int c;
    reset_n         = 1'b0;
    bus.data        = 8'h00;
    bus.data_enable = 1'b0;
    bus.data_last   = 1'b0;
    bus.packet_id   = 16'h0000;
    clearSeen();
    repeat (3) @(negedge clock);
    checkOutput("rst_ready", 32'(bus.ready), 32'd0);
    checkOutput("rst_frag_ready", 32'(bus.fragment_ready), 32'd0);
    checkOutput("rst_push_valid", 32'(bus.push_data_valid), 32'd0);
    checkOutput("rst_overflow", 32'(bus.overflow), 32'd0);
    reset_n = 1'b1;
    @(negedge clock);
    checkOutput("ready_after_reset", 32'(bus.ready), 32'd1);

    // 100-byte datagram: one fragment
    clearSeen();
    applyStimulus(100, 16'h1234, 5);
    waitDone("dg100", 2000);
    checkOutput("pin100_nfrag", n_seen, 1);
    checkOutput("pin100_len", seen_len[0], 100);
    checkOutput("pin100_off", seen_off[0], 0);
    checkOutput("pin100_mf", seen_mf[0], 0);
    checkOutput("pin100_id", seen_id[0], 32'h1234);
    checkOutput("pin100_firsts", first_seen, 1);
    checkOutput("pin100_lasts", last_seen, 1);
    checkOutput("pin100_bytes", bytes_seen, 100);

    // 3000-byte datagram: three fragments
    clearSeen();
    applyStimulus(3000, 16'hA5C3, 17);
    waitDone("dg3000", 8000);
    checkOutput("pin3000_nfrag", n_seen, 3);
    checkOutput("pin3000_len0", seen_len[0], 1480);
    checkOutput("pin3000_len1", seen_len[1], 1480);
    checkOutput("pin3000_len2", seen_len[2], 40);
    checkOutput("pin3000_off1", seen_off[1], 185);
    checkOutput("pin3000_off2", seen_off[2], 370);
    checkOutput("pin3000_mf0", seen_mf[0], 1);
    checkOutput("pin3000_mf2", seen_mf[2], 0);
    checkOutput("pin3000_bytes", bytes_seen, 3000);
    checkOutput("pin3000_no_overflow", overflow_seen, 0);

    // Same datagram with random pull stalls
    clearSeen();
    stall_mode = 1'b1;
    applyStimulus(3000, 16'h0F0F, 33);
    waitDone("dg3000_stall", 20000);
    stall_mode = 1'b0;
    checkOutput("pinstall_nfrag", n_seen, 3);
    checkOutput("pinstall_bytes", bytes_seen, 3000);
    checkOutput("pinstall_lasts", last_seen, 3);

    // Exactly one full fragment
    clearSeen();
    applyStimulus(1480, 16'h0001, 2);
    waitDone("dg1480", 5000);
    checkOutput("pin1480_nfrag", n_seen, 1);
    checkOutput("pin1480_len", seen_len[0], 1480);
    checkOutput("pin1480_mf", seen_mf[0], 0);

    // One byte over a full fragment
    clearSeen();
    applyStimulus(1481, 16'h0002, 3);
    waitDone("dg1481", 5000);
    checkOutput("pin1481_nfrag", n_seen, 2);
    checkOutput("pin1481_len0", seen_len[0], 1480);
    checkOutput("pin1481_mf0", seen_mf[0], 1);
    checkOutput("pin1481_len1", seen_len[1], 1);
    checkOutput("pin1481_off1", seen_off[1], 185);
    checkOutput("pin1481_mf1", seen_mf[1], 0);

    // 4100 bytes into a 4096-byte buffer
    clearSeen();
    applyStimulus(4100, 16'h4100, 11);
    waitDone("dg4100", 12000);
    checkOutput("pin4100_overflows", overflow_seen, 4);
    checkOutput("pin4100_len_sum", len_sum, 4096);
    checkOutput("pin4100_len2", seen_len[2], 1136);

    // Reset while streaming the second fragment
    clearSeen();
    applyStimulus(3000, 16'h7777, 21);
    c = 0;
    while (bytes_seen < 1580 && c < 8000) begin
      @(negedge clock);
      c++;
    end
    checkOutput("midrst_second_frag", n_seen, 2);
    reset_n = 1'b0;
    exp_byte.delete();
    exp_hdr.delete();
    repeat (2) @(negedge clock);
    checkOutput("midrst_push_valid", 32'(bus.push_data_valid), 32'd0);
    checkOutput("midrst_push_data", 32'(bus.push_data), 32'd0);
    checkOutput("midrst_frag_ready", 32'(bus.fragment_ready), 32'd0);
    checkOutput("midrst_frag_len", 32'(bus.fragment_length), 32'd0);
    reset_n = 1'b1;
    @(negedge clock);
    checkOutput("midrst_ready", 32'(bus.ready), 32'd1);
    checkOutput("midrst_quiet", 32'(bus.push_data_valid), 32'd0);

    clearSeen();
    applyStimulus(64, 16'hBEEF, 9);
    waitDone("dg64", 2000);
    checkOutput("pin64_nfrag", n_seen, 1);
    checkOutput("pin64_len", seen_len[0], 64);
    checkOutput("pin64_off", seen_off[0], 0);
    checkOutput("pin64_mf", seen_mf[0], 0);
    checkOutput("pin64_id", seen_id[0], 32'hBEEF);
    checkOutput("pin64_bytes", bytes_seen, 64);

    repeat (5) @(negedge clock);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compare_count, fail_count);
    $finish;
  end

endmodule
